// File: rtl/apb_bridge_ctrl.sv
// APB3 master for the AHB-to-APB bridge: SETUP/ACCESS sequencing, PREADY waits, slave-error/timeout -> two-cycle AHB ERROR.
// Latency: read 3 cycles, write 4 cycles (+1 per wait state); the AHB side is stalled via Hreadyout=0 while busy.
module apb_bridge_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic              Hwrite,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [NSLV-1:0]   tempselx,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready,
    input  logic              Pslverr,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Pwrite,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Hreadyout,
    output logic              Hresp,
    output logic [DATA_W-1:0] Hrdata
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WWAIT  = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_ERR1   = 3'd4;
    localparam logic [2:0] S_ERR2   = 3'd5;

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [NSLV-1:0] sel;
    logic [CNT_W-1:0] cnt;
    logic            accept;
    logic            timed_out;

    // ERR2 doubles as an accept state so a new transfer can follow an error without a bubble.
    assign accept    = (state == S_IDLE) || (state == S_ERR2);
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR2: begin
                if (!valid)               state_nxt = S_IDLE;
                else if (tempselx == '0)  state_nxt = S_ERR1;
                else if (Hwrite)          state_nxt = S_WWAIT;
                else                      state_nxt = S_SETUP;
            end
            S_WWAIT:  state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (Pready)         state_nxt = Pslverr ? S_ERR1 : S_IDLE;
                else if (timed_out) state_nxt = S_ERR1;
            end
            S_ERR1:   state_nxt = S_ERR2;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state  <= S_IDLE;
            Paddr  <= '0;
            Pwrite <= 1'b0;
            sel    <= '0;
            Pwdata <= '0;
            Hrdata <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (accept && valid) begin
                Paddr  <= Haddr;
                Pwrite <= Hwrite;
                sel    <= tempselx;
            end
            if (state == S_WWAIT) begin
                Pwdata <= Hwdata;
            end
            if (state == S_SETUP) begin
                cnt <= '0;
            end else if (state == S_ACCESS && !Pready) begin
                cnt <= cnt + CNT_W'(1);
            end
            // Slave errors must not disturb the last good read data.
            if (state == S_ACCESS && Pready && !Pslverr && !Pwrite) begin
                Hrdata <= Prdata;
            end
        end
    end

    assign Pselx     = (state == S_SETUP || state == S_ACCESS) ? sel : '0;
    assign Penable   = (state == S_ACCESS);
    assign Hreadyout = accept;
    assign Hresp     = (state == S_ERR1) || (state == S_ERR2);

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Directed bench for apb_bridge_ctrl: a driver pushes expected APB and AHB responses into queues,
// independent monitors pop and compare them, and a slave model answers from its own queue.
module tb_apb_bridge_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;
    localparam int TO = 4;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [NS-1:0] sel;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            waits;
        logic          err;
        int            gap;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr;
        logic [NS-1:0] sel;
        logic [DW-1:0] pwdata;
        int            acc;
    } apb_exp_t;

    typedef struct packed {
        int            lat;
        logic          err;
        logic [DW-1:0] hrdata;
    } ahb_exp_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        int            waits;
        logic          err;
    } slv_t;

    logic          Hclk = 1'b0;
    logic          Hresetn = 1'b0;
    logic          valid = 1'b0;
    logic          Hwrite = 1'b0;
    logic [AW-1:0] Haddr = '0;
    logic [NS-1:0] tempselx = '0;
    logic [DW-1:0] Hwdata = '0;
    logic [DW-1:0] Prdata = '0;
    logic          Pready = 1'b0;
    logic          Pslverr = 1'b0;
    logic [AW-1:0] Paddr;
    logic [DW-1:0] Pwdata;
    logic          Pwrite;
    logic [NS-1:0] Pselx;
    logic          Penable;
    logic          Hreadyout;
    logic          Hresp;
    logic [DW-1:0] Hrdata;

    apb_bridge_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NS), .TIMEOUT(TO)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Hwrite(Hwrite), .Haddr(Haddr),
        .tempselx(tempselx), .Hwdata(Hwdata), .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr),
        .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable),
        .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
    );

    always #5 Hclk = ~Hclk;

    int total = 0;
    int bad = 0;
    apb_exp_t apb_q[$];
    ahb_exp_t ahb_q[$];
    slv_t     slv_q[$];
    logic [DW-1:0] m_hrdata = '0;
    logic [DW-1:0] m_pwdata = '0;
    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr, input logic [NS-1:0] sel,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                                input int waits, input logic err, input int gap);
        vec_t v;
        v.wr = wr; v.addr = addr; v.sel = sel; v.wdata = wdata; v.rdata = rdata;
        v.waits = waits; v.err = err; v.gap = gap;
        return v;
    endfunction

    function automatic void push_exp(input vec_t v);
        apb_exp_t p;
        ahb_exp_t a;
        slv_t     s;
        logic     miss;
        logic     tmo;
        miss = (v.sel == '0);
        tmo  = !miss && (v.waits >= TO);
        if (!miss) begin
            if (v.wr) m_pwdata = v.wdata;
            p.addr = v.addr; p.wr = v.wr; p.sel = v.sel; p.pwdata = m_pwdata;
            p.acc  = tmo ? TO : v.waits + 1;
            apb_q.push_back(p);
            s.rdata = v.rdata; s.waits = v.waits; s.err = v.err;
            slv_q.push_back(s);
        end
        a.err = miss || tmo || v.err;
        if (miss)     a.lat = 1;
        else if (tmo) a.lat = (v.wr ? 1 : 0) + TO + 2;
        else          a.lat = (v.wr ? 1 : 0) + v.waits + (v.err ? 3 : 2);
        if (!a.err && !v.wr) m_hrdata = v.rdata;
        a.hrdata = m_hrdata;
        ahb_q.push_back(a);
    endfunction

    task automatic do_xfer(input vec_t v);
        int n;
        repeat (v.gap) @(negedge Hclk);
        n = 0;
        while (Hreadyout !== 1'b1 && n < 50) begin
            @(negedge Hclk);
            n++;
        end
        if (n >= 50) check("accept_wait", Hreadyout, 1'b1);
        valid = 1'b1; Hwrite = v.wr; Haddr = v.addr; tempselx = v.sel; Hwdata = 32'hDEAD_BEEF;
        push_exp(v);
        @(negedge Hclk);
        // A garbage request while stalled must be ignored; Hwdata is only valid in this cycle.
        Hwdata = v.wdata; Haddr = 32'hFFFF_FFFC; tempselx = 3'b100; Hwrite = ~v.wr;
        @(negedge Hclk);
        valid = 1'b0; Hwdata = 32'h0BAD_DA7A;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((ahb_q.size() != 0 || apb_q.size() != 0) && n < 200) begin
            @(negedge Hclk);
            n++;
        end
        check("drain_ahb_q", ahb_q.size(), 0);
        check("drain_apb_q", apb_q.size(), 0);
        check("drain_slv_q", slv_q.size(), 0);
    endtask

    // APB slave model
    initial begin
        slv_t cur;
        int   wleft;
        cur = '0;
        wleft = 0;
        forever begin
            @(negedge Hclk);
            if (!Hresetn) begin
                Pready = 1'b0; Pslverr = 1'b0; wleft = 0;
            end else if (Pselx != '0 && !Penable) begin
                if (slv_q.size() > 0) cur = slv_q.pop_front();
                else cur = '0;
                wleft = cur.waits; Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
            end else if (Penable) begin
                Pready  = (wleft == 0);
                Pslverr = cur.err;
                Prdata  = (wleft == 0) ? cur.rdata : 32'hBADB_AD00;
                if (wleft > 0) wleft--;
            end else begin
                Pready = 1'b0; Pslverr = 1'b0;
            end
        end
    end

    // APB monitor
    initial begin
        logic     prev_en;
        logic     have;
        int       acc;
        apb_exp_t e;
        prev_en = 1'b0; have = 1'b0; acc = 0; e = '0;
        forever begin
            @(negedge Hclk);
            if (!Hresetn) begin
                prev_en = 1'b0; have = 1'b0; acc = 0;
            end else begin
                if (Pselx != '0 && !Penable) begin
                    if (apb_q.size() == 0) begin
                        check("apb_unexpected_psel", Pselx, 0);
                        have = 1'b0;
                    end else begin
                        e = apb_q.pop_front();
                        have = 1'b1; acc = 0;
                        check("setup_paddr", Paddr, e.addr);
                        check("setup_pwrite", Pwrite, e.wr);
                        check("setup_psel", Pselx, e.sel);
                        check("setup_pwdata", Pwdata, e.pwdata);
                    end
                end
                if (Penable) begin
                    acc++;
                    if (have) begin
                        check("access_psel", Pselx, e.sel);
                        check("access_paddr", Paddr, e.addr);
                        check("access_pwdata", Pwdata, e.pwdata);
                    end else begin
                        check("access_without_setup", Penable, 1'b0);
                    end
                end
                if (!Penable && prev_en && have) begin
                    check("access_cycles", acc, e.acc);
                    have = 1'b0;
                end
                prev_en = Penable;
            end
        end
    end

    // AHB response monitor
    initial begin
        logic     prev_rdy;
        int       low;
        int       rsp;
        ahb_exp_t a;
        prev_rdy = 1'b1; low = 0; rsp = 0;
        forever begin
            @(negedge Hclk);
            if (!Hresetn) begin
                prev_rdy = 1'b1; low = 0; rsp = 0;
            end else begin
                if (!Hreadyout) begin
                    low++;
                    if (Hresp) rsp++;
                end else begin
                    if (!prev_rdy) begin
                        if (Hresp) rsp++;
                        if (ahb_q.size() == 0) begin
                            check("ahb_unexpected_done", Hreadyout, 1'b0);
                        end else begin
                            a = ahb_q.pop_front();
                            check("ahb_latency", low, a.lat);
                            check("ahb_resp_cycles", rsp, a.err ? 2 : 0);
                            check("ahb_hresp_done", Hresp, a.err);
                            check("ahb_hrdata", Hrdata, a.hrdata);
                        end
                    end else begin
                        check("idle_hresp", Hresp, 1'b0);
                    end
                    low = 0; rsp = 0;
                end
                prev_rdy = Hreadyout;
            end
        end
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        apb_exp_t p;
        slv_t     s;
        int       n;
        //           wr    addr           sel     wdata          rdata          waits err gap
        vecs[0]  = mk(1'b0, 32'h8000_0010, 3'b010, 32'h0,         32'hCAFE_F00D, 0,   0,  1);
        vecs[1]  = mk(1'b1, 32'h8400_0004, 3'b001, 32'h1234_5678, 32'h0,         3,   0,  2);
        vecs[2]  = mk(1'b0, 32'h8000_0020, 3'b100, 32'h0,         32'hBAD0_0BAD, 1,   1,  1);
        vecs[3]  = mk(1'b1, 32'h8800_0008, 3'b100, 32'hA5A5_5A5A, 32'h0,         0,   0,  0);
        vecs[4]  = mk(1'b0, 32'h8000_0030, 3'b001, 32'h0,         32'h1111_2222, 100, 0,  1);
        vecs[5]  = mk(1'b0, 32'h9000_0000, 3'b000, 32'h0,         32'h0,         0,   0,  1);
        vecs[6]  = mk(1'b0, 32'h8000_0044, 3'b010, 32'h0,         32'h5555_AAAA, 2,   0,  0);
        vecs[7]  = mk(1'b1, 32'h8400_0100, 3'b001, 32'hDEAD_0001, 32'h0,         0,   0,  0);
        vecs[8]  = mk(1'b0, 32'h8800_0010, 3'b100, 32'h0,         32'h7777_0000, 0,   0,  0);
        vecs[9]  = mk(1'b1, 32'h8000_0050, 3'b010, 32'h0F0F_0F0F, 32'h0,         0,   1,  0);
        vecs[10] = mk(1'b1, 32'h8400_0200, 3'b001, 32'h3C3C_C3C3, 32'h0,         0,   0,  0);
        vecs[11] = mk(1'b1, 32'h8800_0040, 3'b100, 32'h0000_0099, 32'h0,         100, 0,  1);
        vecs[12] = mk(1'b1, 32'h8C00_0000, 3'b000, 32'h4444_4444, 32'h0,         0,   0,  1);

        Hresetn = 1'b0;
        repeat (3) @(posedge Hclk);
        #1;
        check("rst_hreadyout", Hreadyout, 1'b1);
        check("rst_pselx", Pselx, 0);
        check("rst_penable", Penable, 1'b0);
        check("rst_hresp", Hresp, 1'b0);
        check("rst_hrdata", Hrdata, 0);
        check("rst_paddr", Paddr, 0);
        check("rst_pwdata", Pwdata, 0);
        @(negedge Hclk);
        Hresetn = 1'b1;
        @(negedge Hclk);
        check("post_rst_hreadyout", Hreadyout, 1'b1);
        check("post_rst_pselx", Pselx, 0);

        for (int i = 0; i < 13; i++) do_xfer(vecs[i]);
        drain();

        // Reset asserted in the middle of an ACCESS phase.
        @(negedge Hclk);
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0060; tempselx = 3'b010;
        p.addr = 32'h8000_0060; p.wr = 1'b0; p.sel = 3'b010; p.pwdata = m_pwdata; p.acc = 4;
        apb_q.push_back(p);
        s.rdata = 32'h6666_6666; s.waits = 3; s.err = 1'b0;
        slv_q.push_back(s);
        @(negedge Hclk);
        valid = 1'b0;
        n = 0;
        while (Penable !== 1'b1 && n < 20) begin
            @(negedge Hclk);
            n++;
        end
        check("mid_rst_reached_access", Penable, 1'b1);
        @(posedge Hclk);
        #1;
        Hresetn = 1'b0;
        #1;
        check("mid_rst_pselx", Pselx, 0);
        check("mid_rst_penable", Penable, 1'b0);
        check("mid_rst_hreadyout", Hreadyout, 1'b1);
        check("mid_rst_hrdata", Hrdata, 0);
        repeat (2) @(negedge Hclk);
        apb_q.delete(); slv_q.delete(); ahb_q.delete();
        m_pwdata = '0; m_hrdata = '0;
        Hresetn = 1'b1;
        @(negedge Hclk);
        check("mid_rst_release_pselx", Pselx, 0);

        do_xfer(mk(1'b0, 32'h8000_0070, 3'b001, 32'h0, 32'h4242_4242, 0, 0, 0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_bridge_ctrl.md
# apb_bridge_ctrl

Parametrised APB3 master controller for the AHB-to-APB bridge, successor to the fixed 32-bit/3-slave APB2 controller. Accepts decoded AHB transfers from the bridge slave interface, runs APB SETUP/ACCESS phases with PREADY wait states, maps PSLVERR and a stalled-PREADY timeout onto a two-cycle AHB ERROR response, and returns registered read data to the AHB side.

## Interface
- ADDR_W, 32, address width (Haddr, Paddr)
- DATA_W, 32, data width (Hwdata, Prdata, Pwdata, Hrdata)
- NSLV, 3, number of APB slaves (width of tempselx, Pselx)
- TIMEOUT, 16, max ACCESS cycles with Pready low before abort; 0 disables; counter width $clog2(TIMEOUT+1)

- Hclk  in  1  single clock; everything is clocked on the rising edge
- Hresetn  in  1  asynchronous active-low reset
- valid  in  1  decoded AHB NONSEQ/SEQ transfer to the bridge this cycle
- Hwrite  in  1  transfer direction (1 = write), sampled with valid
- Haddr  in  ADDR_W  transfer address, sampled with valid
- tempselx  in  NSLV  one-hot slave select from the address decoder, sampled with valid
- Hwdata  in  DATA_W  AHB write data, valid the cycle after the write address is accepted
- Prdata  in  DATA_W  APB read data
- Pready  in  1  APB slave ready
- Pslverr  in  1  APB slave error, qualified by Pready
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Pwrite  out  1  APB direction
- Pselx  out  NSLV  one-hot APB select
- Penable  out  1  APB enable
- Hreadyout  out  1  AHB ready
- Hresp  out  1  AHB response (1 = ERROR)
- Hrdata  out  DATA_W  AHB read data

## Operation
- States: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2. All outputs are decoded from state and datapath registers; there are no combinational paths from inputs to outputs.
- IDLE and ERR2 are accept states (Hreadyout=1). In an accept state with valid=1, the block latches Haddr into Paddr, Hwrite into Pwrite and tempselx into the select register.
  - tempselx==0 (decode miss): next state ERR1.
  - Else, write: next state WWAIT.
  - Else, read: next state SETUP.
  - valid=0: next state IDLE.
- WWAIT: Hreadyout=0; Pwdata<=Hwdata; next state SETUP.
- SETUP: Pselx=select register, Penable=0, Hreadyout=0; timeout counter cleared; next state ACCESS.
- ACCESS: Pselx held, Penable=1, Hreadyout=0.
  - Pready=1, Pslverr=0: next state IDLE; for a read, Hrdata<=Prdata.
  - Pready=1, Pslverr=1: next state ERR1; Hrdata is not updated.
  - Pready=0: counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1, next state ERR1; otherwise the block stays in ACCESS.
- ERR1: Pselx=0, Penable=0, Hresp=1, Hreadyout=0. Next state ERR2.
- ERR2: Hresp=1, Hreadyout=1; new-transfer acceptance is identical to IDLE.
- Pselx and Penable are 0 in every state except SETUP and ACCESS. Paddr, Pwrite and Pwdata hold their last values outside a transfer.
- Hrdata holds its value until the next successful read completes.
- valid is ignored in all states except IDLE and ERR2, because the AHB master is stalled by Hreadyout=0.

## Timing
- Reset (asynchronous, on any Hresetn low): state=IDLE, Hreadyout=1, and every other output and the counter =0. Reset asserted mid-transfer drops Pselx/Penable immediately; the transfer is abandoned.
- Read, zero wait states: accept at cycle 0; SETUP at cycle 1; ACCESS at cycle 2; IDLE with Hreadyout=1 and Hrdata valid at cycle 3.
- Write, zero wait states: accept at cycle 0; WWAIT at cycle 1 (Hwdata captured); SETUP at cycle 2; ACCESS at cycle 3; Hreadyout=1 at cycle 4.
- Each cycle of Pready=0 in ACCESS adds one cycle.
- Timeout: ACCESS lasts at most TIMEOUT cycles, then ERR1 follows.
- Back-to-back transfers: a transfer accepted in the IDLE cycle that completes the previous one has its SETUP in the next cycle. There is no idle APB cycle between transfers.
- Error: Hresp=1 for exactly two cycles; Hreadyout is 0 then 1.
- Decode miss: accept → ERR1 → ERR2, with no APB activity at all.

## Test plan
- Reset: hold Hresetn=0 for 3 cycles, then release → Hreadyout=1, Pselx=0, Penable=0, Hresp=0. Assert Hresetn low during ACCESS → Pselx=0 in the same cycle, before the next Hclk edge.
- Read, zero wait: valid=1, Hwrite=0, Haddr=0x8000_0010, tempselx=3'b010, Prdata=0xCAFE_F00D, Pready=1 → Pselx=010 for 2 cycles, Penable high in cycle 2 only, Hrdata=0xCAFE_F00D with Hreadyout=1 at cycle 3.
- Write with waits: write to 0x8400_0004 with Hwdata=0x1234_5678 and Pready low for 3 ACCESS cycles → Pwdata=0x1234_5678 from SETUP onward, ACCESS lasts 4 cycles, Hreadyout=1 at cycle 7.
- Slave error: Pready=1, Pslverr=1 on a read → Hresp=1 for 2 cycles (Hreadyout 0 then 1); Hrdata unchanged.
- Timeout and decode miss: with TIMEOUT=4 and Pready stuck at 0 → exactly 4 ACCESS cycles, then ERR1/ERR2. valid=1 with tempselx=0 → ERR1/ERR2 and Pselx never asserted.
- Back-to-back: read followed by write, the write presented in the read-completion cycle, then a second write presented in ERR2 → SETUP follows immediately each time; Paddr, Pwrite and Pwdata are correct per transfer.
